instr_fetch_unit: RTL and testbench

Instruction-fetch stage for the 10-bit accumulator-style CPU. It owns the program counter and drives the address of the combinational instruction ROM. It captures the returned word into an IF/ID register for decode. It pre-decodes unconditional jumps and the halt word locally, and accepts branch redirects and stalls from downstream stages.

---
 rtl/cpu_isa_pkg.sv | 26 ++
 rtl/fetch_predecode.sv | 17 +
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants and types shared by the fetch and decode stages of the
// 10-bit accumulator CPU.
package cpu_isa_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 10;

  typedef logic [INSTR_W-1:0] instr_t;

  localparam logic [3:0] JUMP_OP = 4'b1000;
  localparam logic [3:0] BEQ_OP  = 4'b1010;
  localparam logic [3:0] BNE_OP  = 4'b1011;

  localparam instr_t HALT_WORD = 10'b0010000010;
  localparam instr_t NOP_WORD  = 10'b0000000000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input instr_t w);
    return w[INSTR_W-1:INSTR_W-4];
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of a fetched word: spots unconditional jumps and
// the halt word so fetch can act on them without waiting for decode.
module fetch_predecode
  import cpu_isa_pkg::*;
(
  input  instr_t              imem_data,
  output logic                is_jump,
  output logic                is_halt,
  output logic [ADDR_W-1:0]   jump_target
);

  assign is_jump     = (opcode_of(imem_data) == JUMP_OP);
  assign is_halt     = (imem_data == HALT_WORD);
  // Jump targets are a 6-bit absolute address in the low bits of the word.
  assign jump_target = {{(ADDR_W-6){1'b0}}, imem_data[5:0]};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the zero-latency ROM address and
// fills the IF/ID register, resolving jumps and halt locally.
module instr_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   imem_addr,
  input  instr_t              imem_data,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  output instr_t              instr_out,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                instr_valid,
  output logic                halted,
  output logic [CNT_W-1:0]    fetch_count,
  output fetch_state_t        dbg_state
);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  instr_t              r_instr;
  instr_t              w_instr_nxt;
  logic [ADDR_W-1:0]   r_pc_out;
  logic [ADDR_W-1:0]   w_pc_out_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_halted;
  logic                w_halted_nxt;
  logic [CNT_W-1:0]    r_fetch_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_issue;
  logic                w_is_jump;
  logic                w_is_halt;
  logic [ADDR_W-1:0]   w_jump_target;

  fetch_predecode u_predecode (
    .imem_data   (imem_data),
    .is_jump     (w_is_jump),
    .is_halt     (w_is_halt),
    .jump_target (w_jump_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_WORD;
      r_pc_out      <= '0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_pc_out      <= w_pc_out_nxt;
      r_valid       <= w_valid_nxt;
      r_halted      <= w_halted_nxt;
      r_fetch_count <= w_count_nxt;
    end
  end

  // Redirect outranks everything, including a halt fetched down a wrong path.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_RUN && !stall && !w_is_jump && w_is_halt) begin
      w_state_nxt = ST_HALT;
    end
  end

  always_comb begin
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc_out_nxt = r_pc_out;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;
    w_issue      = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt     = redirect_target;
      w_valid_nxt  = 1'b0;
      w_halted_nxt = 1'b0;
    end else if (r_state == ST_HALT) begin
      w_valid_nxt  = 1'b0;
      w_halted_nxt = 1'b1;
    end else if (!stall) begin
      if (w_is_jump) begin
        w_pc_nxt    = w_jump_target;
        w_valid_nxt = 1'b0;
      end else begin
        w_instr_nxt  = imem_data;
        w_pc_out_nxt = r_pc;
        w_valid_nxt  = 1'b1;
        w_issue      = 1'b1;
        if (w_is_halt) begin
          w_halted_nxt = 1'b1;
        end else begin
          w_pc_nxt = r_pc + ADDR_W'(1);
        end
      end
    end
    w_count_nxt = r_fetch_count;
    if (w_issue && (r_fetch_count != {CNT_W{1'b1}})) begin
      w_count_nxt = r_fetch_count + CNT_W'(1);
    end
  end

  assign imem_addr   = r_pc;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural ROM, scoreboard of expected
// {pc_out, instr_out} issues, and one task per scenario.
module tb_instr_fetch_unit;
  import cpu_isa_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [9:0]         imem_addr;
  logic [9:0]         imem_data;
  logic               stall = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [9:0]         redirect_target = '0;
  logic [9:0]         instr_out;
  logic [9:0]         pc_out;
  logic               instr_valid;
  logic               halted;
  logic [15:0]        fetch_count;
  fetch_state_t       dbg_state;

  logic [9:0]  rom [1024];
  logic [19:0] exp_q [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_count = 0;
  logic        sb_en = 1'b1;
  logic        stall_at_edge = 1'b0;

  localparam logic [9:0] JUMP7 = 10'b1000001001;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .halted          (halted),
    .fetch_count     (fetch_count),
    .dbg_state       (dbg_state)
  );

  // Clock / ROM
  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_issue(input logic [9:0] pc, input logic [9:0] word);
    exp_q.push_back({pc, word});
    if (exp_count < 16'hFFFF) exp_count++;
  endtask

  task automatic goto_pc(input logic [9:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    tick();
    redirect_valid  = 1'b0;
  endtask

  // Scoreboard: a fresh issue is instr_valid=1 after an edge where stall was low.
  always @(posedge clk) stall_at_edge = stall;

  always @(negedge clk) begin
    if (sb_en && !rst && instr_valid === 1'b1 && !stall_at_edge) begin
      logic [19:0] exp;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc_out=%0d instr=%h, required no issue", pc_out, instr_out);
      end else begin
        exp = exp_q.pop_front();
        if ({pc_out, instr_out} !== exp) begin
          n_fail++;
          $display("FAIL sb_issue: got pc_out=%0d instr=%h, required pc_out=%0d instr=%h",
                   pc_out, instr_out, exp[19:10], exp[9:0]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({imem_addr, instr_out, pc_out, instr_valid, halted, fetch_count} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0d instr=%h pc_out=%0d v=%b h=%b cnt=%0d, required all 0",
               imem_addr, instr_out, pc_out, instr_valid, halted, fetch_count);
    end
    n_cmp++;
    if (dbg_state !== ST_RUN) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required RUN", dbg_state);
    end
  endtask

  task automatic test_run();
    logic [9:0] words [4];
    words = '{10'h000, 10'h070, 10'h36D, 10'h029};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (imem_addr !== 10'(i)) begin
        n_fail++;
        $display("FAIL run_addr: got %0d required %0d", imem_addr, i);
      end
      expect_issue(10'(i), words[i]);
      tick();
      n_cmp++;
      if (instr_valid !== 1'b1 || fetch_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL run_issue: got v=%b cnt=%0d required v=1 cnt=%0d", instr_valid, fetch_count, exp_count);
      end
    end
    n_cmp++;
    if (fetch_count !== 16'd4) begin
      n_fail++;
      $display("FAIL run_count4: got %0d required 4", fetch_count);
    end
  endtask

  task automatic test_jump();
    goto_pc(10'd7);
    n_cmp++;
    if (imem_addr !== 10'd7 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_setup: got addr=%0d v=%b required addr=7 v=0", imem_addr, instr_valid);
    end
    tick();
    n_cmp++;
    if (imem_addr !== 10'd9 || instr_valid !== 1'b0 || fetch_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL jump_bubble: got addr=%0d v=%b cnt=%0d required addr=9 v=0 cnt=%0d",
               imem_addr, instr_valid, fetch_count, exp_count);
    end
    expect_issue(10'd9, rom[9]);
    tick();
    n_cmp++;
    if (imem_addr !== 10'd10 || pc_out !== 10'd9) begin
      n_fail++;
      $display("FAIL jump_resume: got addr=%0d pc_out=%0d required addr=10 pc_out=9", imem_addr, pc_out);
    end
  endtask

  task automatic test_stall();
    goto_pc(10'd4);
    expect_issue(10'd4, rom[4]);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (imem_addr !== 10'd5 || instr_out !== rom[4] || pc_out !== 10'd4 ||
          instr_valid !== 1'b1 || fetch_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL stall_hold: got addr=%0d instr=%h pc_out=%0d v=%b cnt=%0d required addr=5 instr=%h pc_out=4 v=1 cnt=%0d",
                 imem_addr, instr_out, pc_out, instr_valid, fetch_count, rom[4], exp_count);
      end
    end
    stall = 1'b0;
    expect_issue(10'd5, rom[5]);
    tick();
    n_cmp++;
    if (imem_addr !== 10'd6 || fetch_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL stall_resume: got addr=%0d cnt=%0d required addr=6 cnt=%0d", imem_addr, fetch_count, exp_count);
    end
  endtask

  task automatic test_redirect_stall();
    goto_pc(10'd20);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 10'd28;
    tick();
    stall = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_addr !== 10'd28 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_squash: got addr=%0d v=%b required addr=28 v=0", imem_addr, instr_valid);
    end
    expect_issue(10'd28, rom[28]);
    tick();
    n_cmp++;
    if (instr_valid !== 1'b1 || pc_out !== 10'd28) begin
      n_fail++;
      $display("FAIL redir_issue: got v=%b pc_out=%0d required v=1 pc_out=28", instr_valid, pc_out);
    end
  endtask

  task automatic test_halt();
    goto_pc(10'd40);
    expect_issue(10'd40, HALT_WORD);
    tick();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_out !== HALT_WORD || pc_out !== 10'd40 ||
        halted !== 1'b1 || dbg_state !== ST_HALT || imem_addr !== 10'd40) begin
      n_fail++;
      $display("FAIL halt_issue: got v=%b instr=%h pc_out=%0d h=%b addr=%0d required v=1 instr=%h pc_out=40 h=1 addr=40",
               instr_valid, instr_out, pc_out, halted, imem_addr, HALT_WORD);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (instr_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 10'd40 || fetch_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL halt_hold: got v=%b h=%b addr=%0d cnt=%0d required v=0 h=1 addr=40 cnt=%0d",
                 instr_valid, halted, imem_addr, fetch_count, exp_count);
      end
    end
    goto_pc(10'd3);
    n_cmp++;
    if (halted !== 1'b0 || imem_addr !== 10'd3 || instr_valid !== 1'b0 || dbg_state !== ST_RUN) begin
      n_fail++;
      $display("FAIL halt_exit: got h=%b addr=%0d v=%b required h=0 addr=3 v=0", halted, imem_addr, instr_valid);
    end
    expect_issue(10'd3, rom[3]);
    tick();
    n_cmp++;
    if (instr_valid !== 1'b1 || pc_out !== 10'd3) begin
      n_fail++;
      $display("FAIL halt_resume: got v=%b pc_out=%0d required v=1 pc_out=3", instr_valid, pc_out);
    end
  endtask

  task automatic test_wrap();
    goto_pc(10'd1023);
    expect_issue(10'd1023, rom[1023]);
    tick();
    n_cmp++;
    if (imem_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_pc: got %0d required 0", imem_addr);
    end
    expect_issue(10'd0, rom[0]);
    tick();
    n_cmp++;
    if (imem_addr !== 10'd1 || pc_out !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_next: got addr=%0d pc_out=%0d required addr=1 pc_out=0", imem_addr, pc_out);
    end
  endtask

  task automatic test_reset_in_halt();
    goto_pc(10'd40);
    expect_issue(10'd40, HALT_WORD);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    n_cmp++;
    if ({imem_addr, instr_out, pc_out, instr_valid, halted, fetch_count} !== 48'h0 || dbg_state !== ST_RUN) begin
      n_fail++;
      $display("FAIL halt_reset: got addr=%0d instr=%h pc_out=%0d v=%b h=%b cnt=%0d, required all 0",
               imem_addr, instr_out, pc_out, instr_valid, halted, fetch_count);
    end
  endtask

  task automatic test_saturate();
    rom[7]  = 10'h047;
    rom[40] = 10'h068;
    sb_en = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    n_cmp++;
    if (fetch_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach: got %h required ffff", fetch_count);
    end
    tick();
    n_cmp++;
    if (fetch_count !== 16'hFFFF || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: got cnt=%h v=%b required cnt=ffff v=1", fetch_count, instr_valid);
    end
  endtask

  initial begin
    // Default ROM words use opcode 0001: never a jump, never halt.
    for (int i = 0; i < 1024; i++) rom[i] = {4'b0001, 6'(i)};
    rom[0]  = 10'h000;
    rom[1]  = 10'h070;
    rom[2]  = 10'h36D;
    rom[3]  = 10'h029;
    rom[7]  = JUMP7;
    rom[40] = HALT_WORD;

    test_reset();
    test_run();
    test_jump();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_reset_in_halt();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending issues, required 0", exp_q.size());
    end
    test_saturate();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
